// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit restoring divider for DIV/DIVU/REM/REMU.
// Iterates one quotient bit per cycle. Results are registered and announced by a
// one-cycle div_ready pulse. busy holds the pipeline while an operation is in flight.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   start     in   request a new division (sampled in IDLE or DONE only)
//   op        in   2'b00 DIV, 2'b01 DIVU, 2'b10 REM, 2'b11 REMU (funct3[1:0])
//   a, b      in   dividend (rs1) and divisor (rs2)
//   flush     in   synchronous abort; wins over start
//   divres    out  registered result, held until the next completed operation
//   div_ready out  one-cycle pulse marking divres valid
//   busy      out  high in PREP and CALC
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic [31:0] divres,
    output logic        div_ready,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StPrep, StCalc, StDone} state_e;

    state_e      state_q;
    logic [31:0] a_q;
    logic [31:0] b_q;      // raw divisor after capture, |b| once PREP completes
    logic [1:0]  op_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [4:0]  cnt_q;
    logic        qneg_q;
    logic        rneg_q;

    // Operand preparation (valid while in PREP)
    logic        a_neg, b_neg;
    logic [31:0] abs_a, abs_b;
    logic        div_zero, sgn_ovf;
    logic [31:0] special_res;

    // One restoring step plus the final sign fix-up (valid while in CALC)
    logic [32:0] trial;
    logic        fits;
    logic [31:0] rem_nxt, quo_nxt;
    logic [31:0] q_fin, r_fin, fin_res;

    always_comb begin
        a_neg    = ~op_q[0] & a_q[31];
        b_neg    = ~op_q[0] & b_q[31];
        abs_a    = a_neg ? (32'd0 - a_q) : a_q;
        abs_b    = b_neg ? (32'd0 - b_q) : b_q;
        div_zero = (b_q == 32'd0);
        sgn_ovf  = ~op_q[0] & (a_q == 32'h8000_0000) & (b_q == 32'hFFFF_FFFF);
        if (div_zero) begin
            special_res = op_q[1] ? a_q : 32'hFFFF_FFFF;
        end else begin
            special_res = op_q[1] ? 32'd0 : 32'h8000_0000;
        end

        // The shifted partial remainder is 33 bits wide: rem_q[31] is kept as the
        // trial's top bit so divisors >= 2^31 (DIVU/REMU) still divide correctly.
        trial   = {rem_q, quo_q[31]} - {1'b0, b_q};
        fits    = ~trial[32];
        rem_nxt = fits ? trial[31:0] : {rem_q[30:0], quo_q[31]};
        quo_nxt = {quo_q[30:0], fits};

        q_fin   = qneg_q ? (32'd0 - quo_nxt) : quo_nxt;
        r_fin   = rneg_q ? (32'd0 - rem_nxt) : rem_nxt;
        fin_res = op_q[1] ? r_fin : q_fin;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            op_q      <= 2'd0;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            cnt_q     <= 5'd0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            divres    <= 32'd0;
            div_ready <= 1'b0;
            busy      <= 1'b0;
        end else begin
            div_ready <= 1'b0;
            if (flush) begin
                state_q <= StIdle;
                busy    <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle, StDone: begin
                        if (start) begin
                            a_q     <= a;
                            b_q     <= b;
                            op_q    <= op;
                            state_q <= StPrep;
                            busy    <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                            busy    <= 1'b0;
                        end
                    end
                    StPrep: begin
                        if (div_zero || sgn_ovf) begin
                            divres    <= special_res;
                            div_ready <= 1'b1;
                            state_q   <= StDone;
                            busy      <= 1'b0;
                        end else begin
                            qneg_q  <= a_neg ^ b_neg;
                            rneg_q  <= a_neg;
                            b_q     <= abs_b;
                            rem_q   <= 32'd0;
                            quo_q   <= abs_a;
                            cnt_q   <= 5'd31;
                            state_q <= StCalc;
                        end
                    end
                    StCalc: begin
                        rem_q <= rem_nxt;
                        quo_q <= quo_nxt;
                        cnt_q <= cnt_q - 5'd1;
                        // Last iteration: publish the sign-corrected result directly
                        if (cnt_q == 5'd0) begin
                            divres    <= fin_res;
                            div_ready <= 1'b1;
                            state_q   <= StDone;
                            busy      <= 1'b0;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule
